div_ctrl: RTL and testbench

//  EX-stage sequencer for the 32-bit radix-2 iterative divider. Accepts a DIV/DIVU/REM/REMU request.

---
 rtl/div_ctrl_pkg.sv | 53 +++++
 rtl/div_ctrl_result_cache.sv | 53 +++++
 rtl/div_ctrl.sv | 154 +++++++++++++++
 tb/tb_div_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the divider EX-stage sequencer (div_ctrl).
// Holds operation/state encodings and the special-case resolver.
package div_ctrl_pkg;

  localparam int REG_BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    DIV_ST_IDLE  = 3'd0,
    DIV_ST_SPEC  = 3'd1,
    DIV_ST_START = 3'd2,
    DIV_ST_WAIT  = 3'd3,
    DIV_ST_DONE  = 3'd4
  } div_state_e;

  typedef struct packed {
    logic                     hit;
    logic [REG_BUS_WIDTH-1:0] value;
  } spec_res_t;

  // op[0]=0 selects the signed variants (DIV, REM).
  function automatic logic is_signed_op(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic [REG_BUS_WIDTH-1:0] abs_val(input logic [REG_BUS_WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Divide-by-zero and signed overflow never reach the divider.
  function automatic spec_res_t special_case(input logic [1:0]               op,
                                             input logic [REG_BUS_WIDTH-1:0] a,
                                             input logic [REG_BUS_WIDTH-1:0] b);
    spec_res_t r;
    r = '0;
    if (b == '0) begin
      r.hit   = 1'b1;
      r.value = op[1] ? a : '1;
    end else if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.hit   = 1'b1;
      r.value = op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_ctrl_result_cache.sv
// One-entry cache of the last divider result, so a DIV followed by REM on the
// same operands skips the divider. Only instantiated under DIV_RESULT_CACHE_EN.
module div_result_cache
  import div_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_BUS_WIDTH-1:0] lookup_op1,
  input  logic [REG_BUS_WIDTH-1:0] lookup_op2,
  input  logic                     lookup_signed,
  output logic                     hit,
  output logic [REG_BUS_WIDTH-1:0] hit_quot,
  output logic [REG_BUS_WIDTH-1:0] hit_rem,
  input  logic                     stage_en,
  input  logic [REG_BUS_WIDTH-1:0] stage_quot,
  input  logic [REG_BUS_WIDTH-1:0] stage_rem,
  input  logic                     commit_en,
  input  logic [REG_BUS_WIDTH-1:0] commit_op1,
  input  logic [REG_BUS_WIDTH-1:0] commit_op2,
  input  logic                     commit_signed
);

  logic                     valid_q;
  logic [REG_BUS_WIDTH-1:0] pend_quot_q, pend_rem_q;
  logic [REG_BUS_WIDTH-1:0] ent_op1_q, ent_op2_q, ent_quot_q, ent_rem_q;
  logic                     ent_signed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else if (commit_en) valid_q <= 1'b1;
  end

  // NOTE: data fields need no reset; valid_q alone gates every use of them.
  always_ff @(posedge clk) begin
    if (stage_en) begin
      pend_quot_q <= stage_quot;
      pend_rem_q  <= stage_rem;
    end
    if (commit_en) begin
      ent_op1_q    <= commit_op1;
      ent_op2_q    <= commit_op2;
      ent_signed_q <= commit_signed;
      ent_quot_q   <= pend_quot_q;
      ent_rem_q    <= pend_rem_q;
    end
  end

  assign hit      = valid_q && ent_op1_q == lookup_op1 && ent_op2_q == lookup_op2 &&
                    ent_signed_q == lookup_signed;
  assign hit_quot = ent_quot_q;
  assign hit_rem  = ent_rem_q;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the 32-bit iterative divider: special cases, divider
// handshake, stall and writeback. Optional one-entry cache: DIV_RESULT_CACHE_EN.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  input  logic [1:0]               req_op_i,
  input  logic [REG_BUS_WIDTH-1:0] req_op1_i,
  input  logic [REG_BUS_WIDTH-1:0] req_op2_i,
  input  logic [4:0]               req_rd_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [REG_BUS_WIDTH-1:0] result_o,
  output logic [4:0]               rd_o,
  output logic                     div_start_o,
  output logic                     div_cancel_o,
  output logic                     div_op1_signed_o,
  output logic                     div_op2_signed_o,
  output logic [REG_BUS_WIDTH-1:0] div_op1_o,
  output logic [REG_BUS_WIDTH-1:0] div_op2_o,
  input  logic                     div_stop_i,
  input  logic [REG_BUS_WIDTH-1:0] div_res_i,
  input  logic [REG_BUS_WIDTH-1:0] div_rem_i
);

  div_state_e               state_q, state_d;
  logic [1:0]               op_q;
  logic                     spec_done_q;
  logic                     accept, take_spec, stop_take;
  logic                     req_neg1, req_neg2;
  spec_res_t                spec;
  logic                     cache_hit;
  logic [REG_BUS_WIDTH-1:0] cache_value, spec_value;

  assign accept    = (state_q == DIV_ST_IDLE) && req_valid_i && !flush_i;
  assign spec      = special_case(req_op_i, req_op1_i, req_op2_i);
  assign take_spec = spec.hit || cache_hit;
  assign spec_value = spec.hit ? spec.value : cache_value;
  assign stop_take = (state_q == DIV_ST_WAIT) && div_stop_i && !flush_i;
  assign req_neg1  = is_signed_op(req_op_i) && req_op1_i[REG_BUS_WIDTH-1];
  assign req_neg2  = is_signed_op(req_op_i) && req_op2_i[REG_BUS_WIDTH-1];

`ifdef DIV_RESULT_CACHE_EN
  logic [REG_BUS_WIDTH-1:0] op1_q, op2_q, hit_quot, hit_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      op1_q <= req_op1_i;
      op2_q <= req_op2_i;
    end
  end

  div_result_cache u_cache (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_op1    (req_op1_i),
    .lookup_op2    (req_op2_i),
    .lookup_signed (is_signed_op(req_op_i)),
    .hit           (cache_hit),
    .hit_quot      (hit_quot),
    .hit_rem       (hit_rem),
    .stage_en      (stop_take),
    .stage_quot    (div_res_i),
    .stage_rem     (div_rem_i),
    .commit_en     ((state_q == DIV_ST_DONE) && !flush_i),
    .commit_op1    (op1_q),
    .commit_op2    (op2_q),
    .commit_signed (is_signed_op(op_q))
  );

  assign cache_value = req_op_i[1] ? hit_rem : hit_quot;
`else
  assign cache_hit   = 1'b0;
  assign cache_value = '0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    div_start_o  = 1'b0;
    div_cancel_o = 1'b0;
    unique case (state_q)
      DIV_ST_IDLE: begin
        if (accept) state_d = take_spec ? DIV_ST_SPEC : DIV_ST_START;
      end
      DIV_ST_SPEC: state_d = DIV_ST_IDLE;
      DIV_ST_START: begin
        if (flush_i) begin
          div_cancel_o = 1'b1;
          state_d      = DIV_ST_IDLE;
        end else begin
          div_start_o = 1'b1;
          state_d     = DIV_ST_WAIT;
        end
      end
      DIV_ST_WAIT: begin
        if (flush_i) begin
          div_cancel_o = 1'b1;
          state_d      = DIV_ST_IDLE;
        end else if (div_stop_i) begin
          state_d = DIV_ST_DONE;
        end
      end
      DIV_ST_DONE: state_d = DIV_ST_IDLE;
      default:     state_d = DIV_ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != DIV_ST_IDLE) || accept;

  // Special results surface one cycle after SPEC; divider results while in DONE.
  assign done_o = spec_done_q || ((state_q == DIV_ST_DONE) && !flush_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spec_done_q <= 1'b0;
    else        spec_done_q <= (state_q == DIV_ST_SPEC) && !flush_i;
  end

  // Divider operands stay frozen until the next acceptance: its sign fix-up reads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q             <= '0;
      rd_o             <= '0;
      div_op1_o        <= '0;
      div_op2_o        <= '0;
      div_op1_signed_o <= 1'b0;
      div_op2_signed_o <= 1'b0;
      result_o         <= '0;
    end else if (accept) begin
      op_q             <= req_op_i;
      rd_o             <= req_rd_i;
      div_op1_o        <= abs_val(req_op1_i, req_neg1);
      div_op2_o        <= abs_val(req_op2_i, req_neg2);
      div_op1_signed_o <= req_neg1;
      div_op2_signed_o <= req_neg2;
      if (take_spec) result_o <= spec_value;
    end else if (stop_take) begin
      result_o <= op_q[1] ? div_rem_i : div_res_i;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural divider model.
// Cache-dependent expectations follow DIV_RESULT_CACHE_EN.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, flush_i;
  logic [1:0]  req_op_i;
  logic [31:0] req_op1_i, req_op2_i;
  logic [4:0]  req_rd_i;
  logic        busy_o, done_o, div_start_o, div_cancel_o;
  logic [31:0] result_o, div_op1_o, div_op2_o;
  logic [4:0]  rd_o;
  logic        div_op1_signed_o, div_op2_signed_o;
  logic        div_stop_i;
  logic [31:0] div_res_i, div_rem_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cnt = 0, cancel_cnt = 0, done_cnt = 0;
  int last_stop_cyc = 0, done_cyc = 0;
  int div_lat = 34;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b;

  div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o),
    .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
    .div_op1_signed_o(div_op1_signed_o), .div_op2_signed_o(div_op2_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_stop_i(div_stop_i),
    .div_res_i(div_res_i), .div_rem_i(div_rem_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (div_start_o)  start_cnt++;
    if (div_cancel_o) cancel_cnt++;
    if (done_o)       done_cnt++;
  end

  // Divider model: fixed latency, sign-corrected quotient and remainder.
  initial begin
    int cnt;
    logic signed [31:0] sa, sb;
    cnt = 0;
    div_stop_i = 1'b0;
    div_res_i = '0;
    div_rem_i = '0;
    forever begin
      @(negedge clk);
      #2;
      div_stop_i = 1'b0;
      if (!rst_n || div_cancel_o) cnt = 0;
      else if (div_start_o) cnt = div_lat;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sa = m_a;
          sb = m_b;
          if (m_op[0]) begin
            div_res_i = m_a / m_b;
            div_rem_i = m_a % m_b;
          end else begin
            div_res_i = sa / sb;
            div_rem_i = sa % sb;
          end
          div_stop_i = 1'b1;
          last_stop_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the next falling edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i = op; req_op1_i = a; req_op2_i = b; req_rd_i = rd;
    m_op = op; m_a = a; m_b = b;
    #1 check("busy_on_accept", busy_o, 1'b1);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
  endtask

  // Cycles from acceptance until done_o; called one cycle after acceptance.
  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done_o && lat < 100) begin
      @(negedge clk);
      #1 lat++;
    end
    check({tag, "_done"}, done_o, 1'b1);
    done_cyc = cyc;
  endtask

  // exp_lat > 0: special path with that latency; otherwise divider path.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int s0, lat;
    s0 = start_cnt;
    issue(op, a, b, rd);
    wait_done(tag, lat);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_rd"}, rd_o, rd);
    if (exp_lat > 0) begin
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_nostart"}, start_cnt - s0, 0);
    end else begin
      check({tag, "_stop2done"}, done_cyc - last_stop_cyc, 1);
      check({tag, "_start1"}, start_cnt - s0, 1);
    end
    @(negedge clk);
    #1 check({tag, "_pulse"}, done_o, 1'b0);
  endtask

  initial begin
    int d0, s0, lat, k;
    rst_n = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0;
    req_op_i = '0; req_op1_i = '0; req_op2_i = '0; req_rd_i = '0;
    m_op = '0; m_a = '0; m_b = 32'd1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_op1", div_op1_o, 0);
    check("rst_start", div_start_o, 0);
    rst_n = 1'b1;

    // Signed divide with negative divisor.
    issue(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd1);
    check("neg_op1", div_op1_o, 32'd100);
    check("neg_op2", div_op2_o, 32'd7);
    check("neg_op1s", div_op1_signed_o, 0);
    check("neg_op2s", div_op2_signed_o, 1);
    check("neg_start", div_start_o, 1);
    wait_done("neg", lat);
    check("neg_result", result_o, 32'hFFFF_FFF2);
    check("neg_stop2done", done_cyc - last_stop_cyc, 1);

    run_op("remu_z", 2'b11, 32'd5, 32'd0, 5'd2, 32'd5, 2);
    run_op("divu_z", 2'b01, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 2);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 2);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'd0, 2);
    run_op("rem_z", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFB, 2);
    run_op("div_n", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFF2, 0);
    run_op("rem_n", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'd2, 0);
    run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd16, 5'd9, 32'h0FFF_FFFF, 0);
    run_op("remu", 2'b11, 32'd1000, 32'd7, 5'd10, 32'd6, 0);

    // Flush during WAIT cancels the divider with no writeback.
    issue(2'b00, 32'd1000, 32'd3, 5'd11);
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    d0 = done_cnt;
    #1 check("fl_cancel", div_cancel_o, 1);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("fl_busy", busy_o, 0);
    repeat (40) @(negedge clk);
    check("fl_nodone", done_cnt - d0, 0);
    run_op("after_fl", 2'b00, 32'd9, 32'd3, 5'd12, 32'd3, 0);

    // A held request with new operands is ignored until the FSM returns to IDLE.
    s0 = start_cnt;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 2'b00; req_op1_i = 32'd50; req_op2_i = 32'd5; req_rd_i = 5'd13;
    m_op = 2'b00; m_a = 32'd50; m_b = 32'd5;
    @(negedge clk);
    req_op1_i = 32'd99; req_op2_i = 32'd9; req_rd_i = 5'd14;
    #1 wait_done("hold1", lat);
    check("hold1_result", result_o, 32'd10);
    check("hold1_rd", rd_o, 5'd13);
    @(negedge clk);
    m_a = 32'd99; m_b = 32'd9;
    #1 check("hold2_accept", busy_o, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1 wait_done("hold2", lat);
    check("hold2_result", result_o, 32'd11);
    check("hold2_rd", rd_o, 5'd14);
    check("hold_starts", start_cnt - s0, 2);

    // Reset mid-WAIT clears every output at once.
    issue(2'b00, 32'd1000, 32'd3, 5'd15);
    repeat (5) @(negedge clk);
    #1 check("mid_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_op1", div_op1_o, 0);
    check("mid_rst_op2", div_op2_o, 0);
    check("mid_rst_result", result_o, 0);
    check("mid_rst_rd", rd_o, 0);
    check("mid_rst_flags", {div_op1_signed_o, div_op2_signed_o, div_start_o, div_cancel_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("c_div", 2'b00, 32'd77, 32'd5, 5'd16, 32'd15, 0);
`ifdef DIV_RESULT_CACHE_EN
    k = 2;
`else
    k = 0;
`endif
    run_op("c_rem", 2'b10, 32'd77, 32'd5, 5'd17, 32'd2, k);
    run_op("c_divu", 2'b01, 32'd77, 32'd5, 5'd18, 32'd15, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
